fram_uart_cmd_parser: RTL

Sits directly upstream of the FRAM access FSM and replaces its debug switch/LED interface. Consumes the byte stream from the UART receiver (AXI-Stream) and parses read/write command frames. Issues single-byte memory requests to the FRAM controller over a valid/ready request channel. Returns one reply byte per frame to the UART transmitter stream.

---
 rtl/fram_uart_cmd_parser.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/fram_uart_cmd_parser.sv
// UART command-frame parser in front of the FRAM access controller.
// Frames are: opcode, ADDR_BYTES address bytes (MSB first), and one data byte
// for writes. Each frame produces one memory request and one reply byte.
// A bad opcode produces only a NAK reply. An inter-byte timeout abandons the
// frame silently.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// IDLE        | waiting for an opcode byte
// GET_ADDR    | collecting address bytes, MSB first
// GET_DATA    | collecting the write data byte
// ISSUE       | presenting the request to the FRAM controller
// WAIT_RSP    | request accepted, waiting for the completion strobe
// REPLY       | presenting the reply byte to the UART transmitter
module fram_uart_cmd_parser #(
  parameter int          ADDR_BYTES     = 1,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  OP_WRITE       = 8'h57,
  parameter logic [7:0]  OP_READ        = 8'h52,
  parameter logic [7:0]  ACK_BYTE       = 8'h4B,
  parameter logic [7:0]  NAK_BYTE       = 8'h3F
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              s_axis_rx_tdata,
  input  logic                    s_axis_rx_tvalid,
  output logic                    s_axis_rx_tready,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_write,
  output logic [8*ADDR_BYTES-1:0] req_addr,
  output logic [7:0]              req_wdata,
  input  logic                    rsp_valid,
  input  logic                    rsp_error,
  input  logic [7:0]              rsp_rdata,
  output logic [7:0]              m_axis_tx_tdata,
  output logic                    m_axis_tx_tvalid,
  input  logic                    m_axis_tx_tready,
  output logic                    frame_error,
  output logic                    busy
);

  localparam int AW = 8 * ADDR_BYTES;
  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] TC_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_REPLY
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      addr_cnt_q, addr_cnt_d;
  logic [CW-1:0]   to_cnt_q, to_cnt_d;
  logic            rx_ready_q, rx_ready_d;
  logic            req_valid_q, req_valid_d;
  logic            req_write_q, req_write_d;
  logic [AW-1:0]   req_addr_q, req_addr_d;
  logic [7:0]      req_wdata_q, req_wdata_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            frame_error_q, frame_error_d;
  logic            busy_q, busy_d;

  logic            rx_fire;
  logic            timeout_hit;
  logic            collecting_d;
  logic [AW-1:0]   addr_next;

  // Address register shifted left by one byte with the new byte as LSB.
  generate
    if (ADDR_BYTES == 1) begin : g_addr1
      assign addr_next = s_axis_rx_tdata;
    end else begin : g_addrn
      assign addr_next = {req_addr_q[AW-9:0], s_axis_rx_tdata};
    end
  endgenerate

  assign rx_fire     = s_axis_rx_tvalid && rx_ready_q;
  // tready is already low in the firing cycle, so a byte never races the timeout.
  assign timeout_hit = TO_EN && (state_q == ST_GET_ADDR || state_q == ST_GET_DATA)
                       && (to_cnt_q == TC_LAST);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d       = state_q;
    addr_cnt_d    = addr_cnt_q;
    to_cnt_d      = to_cnt_q;
    req_write_d   = req_write_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    tx_data_d     = tx_data_q;
    frame_error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          if (s_axis_rx_tdata == OP_WRITE) begin
            req_write_d = 1'b1;
            addr_cnt_d  = 2'd0;
            to_cnt_d    = '0;
            state_d     = ST_GET_ADDR;
          end else if (s_axis_rx_tdata == OP_READ) begin
            req_write_d = 1'b0;
            addr_cnt_d  = 2'd0;
            to_cnt_d    = '0;
            state_d     = ST_GET_ADDR;
          end else begin
            tx_data_d     = NAK_BYTE;
            frame_error_d = 1'b1;
            state_d       = ST_REPLY;
          end
        end
      end

      ST_GET_ADDR: begin
        if (timeout_hit) begin
          frame_error_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (rx_fire) begin
          req_addr_d = addr_next;
          to_cnt_d   = '0;
          if (addr_cnt_q == ADDR_LAST) begin
            state_d = req_write_q ? ST_GET_DATA : ST_ISSUE;
          end else begin
            addr_cnt_d = addr_cnt_q + 2'd1;
          end
        end else if (TO_EN) begin
          to_cnt_d = to_cnt_q + CW'(1);
        end
      end

      ST_GET_DATA: begin
        if (timeout_hit) begin
          frame_error_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (rx_fire) begin
          req_wdata_d = s_axis_rx_tdata;
          to_cnt_d    = '0;
          state_d     = ST_ISSUE;
        end else if (TO_EN) begin
          to_cnt_d = to_cnt_q + CW'(1);
        end
      end

      ST_ISSUE: begin
        if (req_valid_q && req_ready) begin
          state_d = ST_WAIT_RSP;
        end
      end

      ST_WAIT_RSP: begin
        if (rsp_valid) begin
          if (rsp_error) begin
            tx_data_d = NAK_BYTE;
          end else if (req_write_q) begin
            tx_data_d = ACK_BYTE;
          end else begin
            tx_data_d = rsp_rdata;
          end
          state_d = ST_REPLY;
        end
      end

      ST_REPLY: begin
        if (tx_valid_q && m_axis_tx_tready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are derived from the next state so they line up with it.
    collecting_d = (state_d == ST_GET_ADDR) || (state_d == ST_GET_DATA);
    rx_ready_d   = ((state_d == ST_IDLE) || collecting_d)
                   && !(TO_EN && collecting_d && (to_cnt_d == TC_LAST));
    req_valid_d  = (state_d == ST_ISSUE);
    tx_valid_d   = (state_d == ST_REPLY);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and output registers; async reset drops every handshake at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_cnt_q    <= 2'd0;
      to_cnt_q      <= '0;
      rx_ready_q    <= 1'b0;
      req_valid_q   <= 1'b0;
      req_write_q   <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= 8'h00;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_cnt_q    <= addr_cnt_d;
      to_cnt_q      <= to_cnt_d;
      rx_ready_q    <= rx_ready_d;
      req_valid_q   <= req_valid_d;
      req_write_q   <= req_write_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
    end
  end

  assign s_axis_rx_tready = rx_ready_q;
  assign req_valid        = req_valid_q;
  assign req_write        = req_write_q;
  assign req_addr         = req_addr_q;
  assign req_wdata        = req_wdata_q;
  assign m_axis_tx_tdata  = tx_data_q;
  assign m_axis_tx_tvalid = tx_valid_q;
  assign frame_error      = frame_error_q;
  assign busy             = busy_q;

endmodule
